// File: rtl/weight_streamer.sv
// weight_streamer: reads `count` consecutive wide weights from a weight medium's
// CPU port and streams them through a 2-entry FIFO, keeping one read in flight.
module weight_streamer #(
    parameter int  ADDRS      = 256,
    parameter int  BRAM_WIDTH = 64,
    parameter int  PIECES     = 48,
    localparam int ADDR_SIZE  = $clog2(ADDRS),
    localparam int WIDTH      = PIECES * BRAM_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [ADDR_SIZE-1:0] base_addr_in,
    input  logic [ADDR_SIZE:0]   count_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [ADDR_SIZE-1:0] addr_out,
    output logic                 read_enable_out,
    output logic                 write_enable_out,
    input  logic [WIDTH-1:0]     weight_in,
    input  logic                 finished_in,
    output logic [WIDTH-1:0]     weight_out,
    output logic                 weight_valid_out,
    input  logic                 weight_ready_in,
    output logic                 last_out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [ADDR_SIZE:0]   count_q, issued_q, popped_q;
    logic                 outstanding_q;
    logic [1:0]           occ_q;
    logic [WIDTH-1:0]     head_q, tail_q;
    logic                 issue, capture, pop, last_head;

    // A read goes out only when its result is guaranteed a FIFO slot.
    assign issue     = (state_q == S_RUN) && !outstanding_q &&
                       ((occ_q + {1'b0, outstanding_q}) < 2'd2) &&
                       (issued_q < count_q);
    assign capture   = (state_q == S_RUN) && outstanding_q && finished_in;
    assign pop       = weight_valid_out && weight_ready_in;
    assign last_head = (popped_q == (count_q - 1'b1));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = (count_in == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pop && last_head) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_out         = (state_q == S_RUN);
        done_out         = (state_q == S_DONE);
        read_enable_out  = issue;
        weight_valid_out = (occ_q != 2'd0);
        last_out         = weight_valid_out && last_head;
    end

    assign write_enable_out = 1'b0;
    assign addr_out         = addr_q;
    assign weight_out       = head_q;

    // addr_q advances on completion, so it stays put while a read is in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q        <= '0;
            count_q       <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            outstanding_q <= 1'b0;
            occ_q         <= 2'd0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            if ((state_q == S_IDLE) && start_in) begin
                addr_q        <= base_addr_in;
                count_q       <= count_in;
                issued_q      <= '0;
                popped_q      <= '0;
                outstanding_q <= 1'b0;
            end
            if (issue) begin
                outstanding_q <= 1'b1;
                issued_q      <= issued_q + 1'b1;
            end
            if (capture) begin
                outstanding_q <= 1'b0;
                addr_q        <= addr_q + 1'b1;
            end
            if (pop) begin
                popped_q <= popped_q + 1'b1;
            end
            case (occ_q)
                2'd0: begin
                    if (capture) begin
                        head_q <= weight_in;
                        occ_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (capture && pop) begin
                        head_q <= weight_in;
                    end else if (capture) begin
                        tail_q <= weight_in;
                        occ_q  <= 2'd2;
                    end else if (pop) begin
                        occ_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (capture) begin
                            tail_q <= weight_in;
                        end else begin
                            occ_q <= 2'd1;
                        end
                    end
                end
                default: occ_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_streamer.sv
// Scoreboard bench for weight_streamer: a medium model answers reads 3 cycles
// later; expected addresses/words are queued per job and popped by a monitor.
module tb_weight_streamer;

    localparam int ADDRS      = 16;
    localparam int BRAM_WIDTH = 8;
    localparam int PIECES     = 2;
    localparam int AW         = 4;
    localparam int W          = 16;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [AW-1:0] base_addr_in;
    logic [AW:0]   count_in;
    logic          busy_out, done_out, read_enable_out, write_enable_out;
    logic [AW-1:0] addr_out;
    logic [W-1:0]  weight_in;
    logic          finished_in;
    logic [W-1:0]  weight_out;
    logic          weight_valid_out, weight_ready_in, last_out;

    always #5 clk = ~clk;

    weight_streamer #(.ADDRS(ADDRS), .BRAM_WIDTH(BRAM_WIDTH), .PIECES(PIECES)) dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
        .base_addr_in(base_addr_in), .count_in(count_in),
        .busy_out(busy_out), .done_out(done_out), .addr_out(addr_out),
        .read_enable_out(read_enable_out), .write_enable_out(write_enable_out),
        .weight_in(weight_in), .finished_in(finished_in),
        .weight_out(weight_out), .weight_valid_out(weight_valid_out),
        .weight_ready_in(weight_ready_in), .last_out(last_out)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_data_q[$];
    logic         exp_last_q[$];
    int           exp_addr_q[$];
    int           n_reads = 0, n_done = 0, n_valid = 0;
    bit           spurious_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Medium: answers each read 3 cycles later with 16'hA000+addr; shares reset.
    int           cyc = 0;
    int           due_q[$];
    int           maddr_q[$];
    logic         rst_edge;
    always begin
        @(posedge clk);
        rst_edge = rst_in;
        cyc++;
        #2;
        finished_in = 1'b0;
        weight_in   = W'($urandom);
        if (rst_edge) begin
            due_q.delete();
            maddr_q.delete();
        end else begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                finished_in = 1'b1;
                weight_in   = 16'hA000 + W'(maddr_q[0]);
                void'(due_q.pop_front());
                void'(maddr_q.pop_front());
            end else if (due_q.size() == 0 && spurious_en && ($urandom % 6 == 0)) begin
                finished_in = 1'b1;
            end
            if (read_enable_out) begin
                due_q.push_back(cyc + 3);
                maddr_q.push_back(int'(addr_out));
            end
        end
    end

    // Monitor: reads and stream transfers are compared against the queues.
    bit           hold_pend = 0;
    logic [W-1:0] hold_data;
    logic         hold_last;
    always @(negedge clk) begin
        if (read_enable_out) begin
            n_reads++;
            if (exp_addr_q.size() == 0) chk("unexpected_read", 1, 0);
            else chk("read_addr", 32'(addr_out), 32'(exp_addr_q.pop_front()));
        end
        if (done_out) begin
            n_done++;
            chk("busy_at_done", 32'(busy_out), 0);
        end
        chk("write_enable", 32'(write_enable_out), 0);
        if (weight_valid_out) n_valid++;
        if (hold_pend && !rst_in) begin
            chk("hold_valid", 32'(weight_valid_out), 1);
            chk("hold_data", 32'(weight_out), 32'(hold_data));
            chk("hold_last", 32'(last_out), 32'(hold_last));
        end
        hold_pend = weight_valid_out && !weight_ready_in;
        hold_data = weight_out;
        hold_last = last_out;
        if (weight_valid_out && weight_ready_in) begin
            if (exp_data_q.size() == 0) begin
                chk("unexpected_word", 32'(weight_out), 0);
            end else begin
                chk("word_data", 32'(weight_out), 32'(exp_data_q.pop_front()));
                chk("word_last", 32'(last_out), 32'(exp_last_q.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_job(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            exp_data_q.push_back(16'hA000 + W'((base + i) % ADDRS));
            exp_last_q.push_back(i == cnt - 1);
            exp_addr_q.push_back((base + i) % ADDRS);
        end
    endtask

    task automatic pulse_start(input int base, input int cnt);
        start_in     = 1'b1;
        base_addr_in = AW'(base);
        count_in     = (AW+1)'(cnt);
        tick();
        start_in     = 1'b0;
        base_addr_in = AW'($urandom);
        count_in     = (AW+1)'($urandom);
        if (cnt > 0) begin
            @(negedge clk);
            chk("first_read_next_cycle", 32'(read_enable_out), 1);
            chk("busy_after_start", 32'(busy_out), 1);
        end
    endtask

    task automatic wait_done(input int d0, input bit rmode, input bit poke);
        int c;
        c = 0;
        while (n_done == d0 && c < 3000) begin
            weight_ready_in = rmode ? 1'($urandom) : 1'b1;
            if (poke && c == 5) begin
                start_in     = 1'b1;
                base_addr_in = 4'd11;
                count_in     = 5'd2;
            end else begin
                start_in = 1'b0;
            end
            tick();
            c++;
        end
        start_in = 1'b0;
        if (n_done == d0) chk("done_timeout", 0, 1);
        weight_ready_in = 1'b1;
        tick();
        @(negedge clk);
        chk("single_done", 32'(n_done - d0), 1);
        chk("busy_after_done", 32'(busy_out), 0);
        chk("done_is_pulse", 32'(done_out), 0);
        chk("words_left", 32'(exp_data_q.size()), 0);
        chk("reads_left", 32'(exp_addr_q.size()), 0);
    endtask

    task automatic run_job(input int base, input int cnt, input bit rmode, input bit poke);
        int d0;
        d0 = n_done;
        expect_job(base, cnt);
        tick();
        pulse_start(base, cnt);
        wait_done(d0, rmode, poke);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy_out), 0);
        chk({tag, "_done"}, 32'(done_out), 0);
        chk({tag, "_re"}, 32'(read_enable_out), 0);
        chk({tag, "_valid"}, 32'(weight_valid_out), 0);
        chk({tag, "_last"}, 32'(last_out), 0);
        chk({tag, "_addr"}, 32'(addr_out), 0);
        chk({tag, "_weight"}, 32'(weight_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int d0, r0, v0, base, cnt;
        bit seen;
        rst_in = 1'b1; start_in = 1'b0; base_addr_in = '0; count_in = '0;
        weight_ready_in = 1'b1;
        tick(); tick();
        @(negedge clk);
        check_idle_outputs("reset");
        tick();
        rst_in = 1'b0;

        // Basic, wrap, and full-wrap jobs with ready held high
        run_job(2, 3, 1'b0, 1'b0);
        run_job(14, 4, 1'b0, 1'b0);
        run_job(5, 16, 1'b0, 1'b0);

        // Backpressure: ready low for 20 cycles
        d0 = n_done;
        expect_job(0, 5);
        weight_ready_in = 1'b0;
        tick();
        r0 = n_reads;
        pulse_start(0, 5);
        repeat (20) tick();
        @(negedge clk);
        chk("bp_reads", 32'(n_reads - r0), 2);
        chk("bp_re_low", 32'(read_enable_out), 0);
        chk("bp_valid", 32'(weight_valid_out), 1);
        chk("bp_head", 32'(weight_out), 32'h0000A000);
        wait_done(d0, 1'b0, 1'b0);

        // Zero count
        d0 = n_done; r0 = n_reads; v0 = n_valid;
        tick();
        pulse_start(0, 0);
        @(negedge clk);
        seen = done_out;
        tick();
        @(negedge clk);
        seen = seen | done_out;
        chk("zero_done_by_2nd", 32'(seen), 1);
        repeat (4) tick();
        chk("zero_one_done", 32'(n_done - d0), 1);
        chk("zero_no_reads", 32'(n_reads - r0), 0);
        chk("zero_no_valid", 32'(n_valid - v0), 0);

        // Start pulse mid-job is ignored
        run_job(3, 6, 1'b0, 1'b1);

        // Reset during the second outstanding read
        d0 = n_done;
        expect_job(5, 6);
        tick();
        pulse_start(5, 6);
        r0 = n_reads;
        for (int c = 0; c < 50 && n_reads < r0 + 1; c++) tick();
        chk("second_read_seen", 32'(n_reads - r0), 1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        exp_data_q.delete(); exp_last_q.delete(); exp_addr_q.delete();
        r0 = n_reads; v0 = n_valid;
        repeat (8) tick();
        chk("reset_no_done", 32'(n_done - d0), 0);
        chk("reset_no_reads", 32'(n_reads - r0), 0);
        chk("reset_no_valid", 32'(n_valid - v0), 0);
        run_job(9, 3, 1'b0, 1'b0);

        // Randomized jobs with random ready and stray completions
        spurious_en = 1'b1;
        for (int j = 0; j < 8; j++) begin
            base = int'($urandom % ADDRS);
            cnt  = 1 + int'($urandom % ADDRS);
            run_job(base, cnt, 1'b1, 1'b0);
        end
        run_job(int'($urandom % ADDRS), ADDRS, 1'b1, 1'b0);
        spurious_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_streamer.md
Name: weight_streamer

Overview:
- Read-side client of a weight medium's CPU port.
- Given a base address and a count, it issues sequential single-word read requests and captures each wide weight when the medium signals completion.
- Buffers up to two weights in a 2-entry FIFO and presents them to a downstream consumer (matrix/accumulator datapath) over a valid/ready stream, flagging the last word.
- Prefetches: the next read is issued while a buffered weight waits for the consumer.

Parameters:
- ADDRS, 256, number of wide weight words in the medium; ADDR_SIZE = $clog2(ADDRS).
- BRAM_WIDTH, 64, bits per BRAM piece.
- PIECES, 48, BRAM pieces per weight word; WIDTH = PIECES*BRAM_WIDTH.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous active-high reset.
- start_in  input  1  one-cycle start pulse; sampled only in IDLE.
- base_addr_in  input  ADDR_SIZE  first weight address, latched on start.
- count_in  input  ADDR_SIZE+1  number of weights (0..ADDRS), latched on start.
- busy_out  output  1  high from the cycle after an accepted start until done_out.
- done_out  output  1  one-cycle pulse when the job completes.
- addr_out  output  ADDR_SIZE  to medium addr_in; held stable while a read is outstanding.
- read_enable_out  output  1  one-cycle read request pulse to the medium.
- write_enable_out  output  1  to medium write_enable; constant 0.
- weight_in  input  WIDTH  medium weight_out; valid in the cycle finished_in is high.
- finished_in  input  1  medium completion pulse, one cycle per request.
- weight_out  output  WIDTH  FIFO head data.
- weight_valid_out  output  1  FIFO non-empty.
- weight_ready_in  input  1  consumer ready; a transfer occurs when valid && ready.
- last_out  output  1  qualifies weight_out as the final word of the job.

Behaviour:
- Reset values: busy_out, done_out, read_enable_out, write_enable_out, weight_valid_out and last_out are 0; addr_out is 0; weight_out is 0. FIFO and counters are cleared.
- Reset mid-job aborts the job: state returns to IDLE, buffered data is discarded, and no done_out pulse is generated. The medium shares rst_in, so no stale finished_in arrives afterwards.
- FSM states:
  - IDLE: on start_in with count_in>0, latch addr and count, clear issued/received counters, go to RUN. With count_in==0, go to DONE.
  - RUN: runs the issue and capture rules below.
  - DONE: done_out=1 for exactly one cycle, busy_out drops in the same cycle, then return to IDLE.
- Issue rule (RUN): assert read_enable_out for one cycle when all of these hold:
  - no read is outstanding;
  - FIFO occupancy plus outstanding count < 2;
  - issued < count.
  - addr_out = base + issued, modulo ADDRS (wraps from ADDRS-1 to 0).
  - The first read_enable_out is asserted the cycle after the accepted start.
- Exactly one read may be outstanding at a time. The outstanding flag is set with read_enable_out and cleared by finished_in.
- Capture: on finished_in, push weight_in into the FIFO and increment received. finished_in with no outstanding read is ignored.
- Next issue timing: the next read_enable_out may assert in the cycle after finished_in, if a slot is free.
- FIFO: 2 entries, registered outputs, first-word-fall-through.
  - Push and pop in the same cycle are both honoured, occupancy unchanged.
  - Pop only when weight_ready_in && weight_valid_out.
- last_out is high while the head entry is word number count-1.
- Completion: RUN goes to DONE in the cycle after the handshake of the last word.
- start_in while busy is ignored; the latched parameters are unchanged.
- weight_out and weight_valid_out hold stable while valid && !ready.
- count_in == ADDRS covers every address exactly once, including the wrap.

Test Plan:
- Test configuration: ADDRS=16, BRAM_WIDTH=8, PIECES=2. The medium model returns mem[a] = 16'hA000+a, with finished_in 3 cycles after read_enable_out.
- Basic run: start base=2, count=3, ready held high.
  - Required: reads at addresses 2, 3, 4 in order.
  - Required: stream 16'hA002, 16'hA003, 16'hA004 with last_out on the third word only.
  - Required: one done_out pulse, then busy_out=0.
- Wrap: base=14, count=4 -> addr_out sequence 14, 15, 0, 1; data 16'hA00E, 16'hA00F, 16'hA000, 16'hA001.
- Backpressure: count=5, ready held low 20 cycles.
  - Required: exactly 2 reads issued, then read_enable_out stays low.
  - Required: weight_out holds 16'hA000 stable throughout.
  - Required: after ready rises, all 5 words arrive in order with no loss or duplication.
- Zero count: start with count_in=0 -> no read_enable_out; done_out pulses in the 2nd cycle after start; weight_valid_out never rises.
- Ignored start and reset:
  - A start pulse mid-job with different base/count -> original sequence unaffected.
  - Assert rst_in during the 2nd outstanding read -> all outputs 0 next cycle; no done_out pulse.
  - A fresh start after reset -> runs correctly from its own base.
